// File: rtl/axi_rd_slave128_mem.sv
// AXI4 128-bit read-channel slave backed by a single-port SRAM with 1-cycle
// read latency. One burst outstanding; two-beat buffering absorbs rready stalls.
module axi_rd_slave128_mem #(
  parameter int unsigned ADDR_W = 40,
  parameter int unsigned ID_W   = 8,
  parameter int unsigned MEM_AW = 16
) (
  input  logic              pll_core_cpuclk,
  input  logic              pad_cpu_rst,
  input  logic              biu_pad_arvalid,
  input  logic [ADDR_W-1:0] biu_pad_araddr,
  input  logic [ID_W-1:0]   biu_pad_arid,
  input  logic [7:0]        biu_pad_arlen,
  input  logic [2:0]        biu_pad_arsize,
  input  logic [1:0]        biu_pad_arburst,
  output logic              pad_biu_arready,
  output logic              pad_biu_rvalid,
  output logic [127:0]      pad_biu_rdata,
  output logic [ID_W-1:0]   pad_biu_rid,
  output logic [1:0]        pad_biu_rresp,
  output logic              pad_biu_rlast,
  input  logic              biu_pad_rready,
  output logic              mem_cen,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [127:0]      mem_rdata
);

  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q, state_d;

  logic              live_q;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic              err_q;
  logic [8:0]        issue_cnt;
  logic              inflight_q;
  logic              inflight_last_q;

  logic [127:0]      fifo_data [2];
  logic              fifo_last [2];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        fifo_cnt;

  logic [ADDR_W-1:0] step, wmask, addr_nxt;

  logic ar_hs, r_hs, ar_err, beats_left, issue, push, pop;
  logic [1:0] occ;
  logic [127:0] beat_data;

  assign ar_hs = biu_pad_arvalid & pad_biu_arready;
  assign r_hs  = pad_biu_rvalid & biu_pad_rready;

  assign ar_err = (|biu_pad_araddr[ADDR_W-1:MEM_AW+4])
               || (biu_pad_arburst == 2'b11)
               || (biu_pad_arsize > 3'd4)
               || ((biu_pad_arburst == 2'b10)
                   && !(biu_pad_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

  // In-flight read plus buffered beats never exceed the two buffer slots.
  assign occ        = fifo_cnt + {1'b0, inflight_q};
  assign beats_left = (state_q == BURST) && (issue_cnt <= {1'b0, len_q});
  assign issue      = beats_left && (occ < 2'd2);

  // Error bursts flow through the same pipeline with zero data and no SRAM access.
  assign beat_data = err_q ? '0 : mem_rdata;
  // With an empty buffer the returning word is presented directly and only
  // parked in the buffer if the master does not take it this cycle.
  assign push = inflight_q && !((fifo_cnt == 2'd0) && biu_pad_rready);
  assign pop  = (fifo_cnt != 2'd0) && biu_pad_rready;

  assign mem_cen     = !(issue && !err_q);
  assign mem_addr    = addr_q[MEM_AW+3:4];
  assign pad_biu_rid = id_q;

  // FSM state register
  always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
    if (pad_cpu_rst) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ar_hs) state_d = BURST;
      BURST:   if (r_hs && pad_biu_rlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: AR accepted only in IDLE and not before the first edge out of reset
  always_comb begin
    pad_biu_arready = live_q && (state_q == IDLE);
  end

  // Next beat address for the captured burst type
  always_comb begin
    step  = ADDR_W'(1) << size_q;
    wmask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
    case (burst_q)
      2'b00:   addr_nxt = addr_q;
      2'b10:   addr_nxt = (addr_q & ~wmask) | ((addr_q + step) & wmask);
      default: addr_nxt = addr_q + step;
    endcase
  end

  // Request capture, beat issue and in-flight tracking
  always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
    if (pad_cpu_rst) begin
      live_q          <= 1'b0;
      id_q            <= '0;
      addr_q          <= '0;
      len_q           <= '0;
      size_q          <= '0;
      burst_q         <= '0;
      err_q           <= 1'b0;
      issue_cnt       <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      live_q     <= 1'b1;
      inflight_q <= issue;
      if (ar_hs) begin
        id_q      <= biu_pad_arid;
        addr_q    <= biu_pad_araddr;
        len_q     <= biu_pad_arlen;
        size_q    <= biu_pad_arsize;
        burst_q   <= biu_pad_arburst;
        err_q     <= ar_err;
        issue_cnt <= '0;
      end else if (issue) begin
        addr_q          <= addr_nxt;
        issue_cnt       <= issue_cnt + 9'd1;
        inflight_last_q <= (issue_cnt == {1'b0, len_q});
      end
    end
  end

  // Two-entry return buffer
  always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
    if (pad_cpu_rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= beat_data;
        fifo_last[wr_ptr] <= inflight_last_q;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // R channel driven from the buffer head, or the returning word when empty
  always_comb begin
    pad_biu_rvalid = (fifo_cnt != 2'd0) || inflight_q;
    pad_biu_rdata  = '0;
    pad_biu_rlast  = 1'b0;
    pad_biu_rresp  = 2'b00;
    if (fifo_cnt != 2'd0) begin
      pad_biu_rdata = fifo_data[rd_ptr];
      pad_biu_rlast = fifo_last[rd_ptr];
      pad_biu_rresp = err_q ? 2'b10 : 2'b00;
    end else if (inflight_q) begin
      pad_biu_rdata = beat_data;
      pad_biu_rlast = inflight_last_q;
      pad_biu_rresp = err_q ? 2'b10 : 2'b00;
    end
  end

endmodule

// File: tb/tb_axi_rd_slave128_mem.sv
// Self-checking bench for axi_rd_slave128_mem: directed bursts plus random
// bursts compared against a behavioural address/response model.
module tb_axi_rd_slave128_mem;

  localparam int unsigned ADDR_W = 40;
  localparam int unsigned ID_W   = 8;
  localparam int unsigned MEM_AW = 16;

  logic              pll_core_cpuclk = 1'b0;
  logic              pad_cpu_rst = 1'b1;
  logic              biu_pad_arvalid = 1'b0;
  logic [ADDR_W-1:0] biu_pad_araddr = '0;
  logic [ID_W-1:0]   biu_pad_arid = '0;
  logic [7:0]        biu_pad_arlen = '0;
  logic [2:0]        biu_pad_arsize = '0;
  logic [1:0]        biu_pad_arburst = '0;
  logic              pad_biu_arready;
  logic              pad_biu_rvalid;
  logic [127:0]      pad_biu_rdata;
  logic [ID_W-1:0]   pad_biu_rid;
  logic [1:0]        pad_biu_rresp;
  logic              pad_biu_rlast;
  logic              biu_pad_rready = 1'b0;
  logic              mem_cen;
  logic [MEM_AW-1:0] mem_addr;
  logic [127:0]      mem_rdata = '0;

  axi_rd_slave128_mem #(.ADDR_W(ADDR_W), .ID_W(ID_W), .MEM_AW(MEM_AW)) dut (
    .pll_core_cpuclk (pll_core_cpuclk),
    .pad_cpu_rst     (pad_cpu_rst),
    .biu_pad_arvalid (biu_pad_arvalid),
    .biu_pad_araddr  (biu_pad_araddr),
    .biu_pad_arid    (biu_pad_arid),
    .biu_pad_arlen   (biu_pad_arlen),
    .biu_pad_arsize  (biu_pad_arsize),
    .biu_pad_arburst (biu_pad_arburst),
    .pad_biu_arready (pad_biu_arready),
    .pad_biu_rvalid  (pad_biu_rvalid),
    .pad_biu_rdata   (pad_biu_rdata),
    .pad_biu_rid     (pad_biu_rid),
    .pad_biu_rresp   (pad_biu_rresp),
    .pad_biu_rlast   (pad_biu_rlast),
    .biu_pad_rready  (biu_pad_rready),
    .mem_cen         (mem_cen),
    .mem_addr        (mem_addr),
    .mem_rdata       (mem_rdata)
  );

  always #5 pll_core_cpuclk = ~pll_core_cpuclk;

  typedef struct {
    logic [127:0] data;
    logic [1:0]   resp;
    logic         last;
    logic [7:0]   id;
    int           cyc;
  } beat_t;

  beat_t       r_q[$];
  logic [15:0] mem_q[$];
  int          mem_cyc[$];
  logic [39:0] exp_a[$];
  logic        exp_err;

  int vectors = 0, errs = 0, cyc = 0;
  int issued_tot = 0, accepted_tot = 0, max_out = 0, stab_err = 0;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data;
  logic [1:0]   prev_resp;
  logic         prev_last;
  logic [7:0]   prev_id;

  // Distinct, address-dependent SRAM contents
  function automatic logic [127:0] word_of(input logic [15:0] wa);
    return {16'hC0DE, wa, ~wa, 16'h5A5A ^ wa, wa * 16'd7, 16'h1234 + wa,
            wa[7:0], wa[15:8], 16'hBEEF};
  endfunction

  always @(posedge pll_core_cpuclk) cyc <= cyc + 1;

  // SRAM: one-cycle read latency
  always @(posedge pll_core_cpuclk)
    if (!mem_cen) mem_rdata <= word_of(mem_addr);

  // Bus monitor: log SRAM reads and accepted beats, track outstanding depth and stall stability
  always @(negedge pll_core_cpuclk) begin
    if (pad_cpu_rst) begin
      prev_stall = 1'b0;
    end else begin
      beat_t b;
      if (!mem_cen) begin
        mem_q.push_back(mem_addr);
        mem_cyc.push_back(cyc);
        issued_tot++;
      end
      if (issued_tot - accepted_tot > max_out) max_out = issued_tot - accepted_tot;
      if (prev_stall && !(pad_biu_rvalid && pad_biu_rdata === prev_data && pad_biu_rresp === prev_resp
                          && pad_biu_rlast === prev_last && pad_biu_rid === prev_id))
        stab_err++;
      if (pad_biu_rvalid && biu_pad_rready) begin
        b.data = pad_biu_rdata; b.resp = pad_biu_rresp; b.last = pad_biu_rlast;
        b.id = pad_biu_rid; b.cyc = cyc;
        r_q.push_back(b);
        accepted_tot++;
      end
      prev_stall = pad_biu_rvalid && !biu_pad_rready;
      prev_data = pad_biu_rdata; prev_resp = pad_biu_rresp;
      prev_last = pad_biu_rlast; prev_id = pad_biu_rid;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: byte address of every beat and the burst-wide error verdict
  task automatic model(input logic [39:0] a, input logic [7:0] len, input logic [2:0] size,
                       input logic [1:0] burst);
    longint unsigned addr, s, w, base;
    exp_a.delete();
    exp_err = (a >= 40'h10_0000) || (burst == 2'b11) || (size > 3'd4)
           || (burst == 2'b10 && len != 8'd1 && len != 8'd3 && len != 8'd7 && len != 8'd15);
    s = 64'd1 << size;
    w = (64'(len) + 64'd1) * s;
    addr = 64'(a);
    for (int i = 0; i <= int'(len); i++) begin
      exp_a.push_back(40'(addr));
      if (burst == 2'b01) begin
        addr = (addr + s) % (64'd1 << 40);
      end else if (burst == 2'b10) begin
        base = addr - (addr % w);
        addr = base + ((addr - base + s) % w);
      end
    end
  endtask

  function automatic logic pick_rready(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 3 == 0);
    return 1'($urandom_range(0, 1));
  endfunction

  // One complete burst: AR handshake, drive rready per mode, check against the model
  task automatic do_burst(input logic [39:0] a, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [7:0] id, input int mode);
    int waitc, k, nb;
    logic [15:0] wa;
    model(a, len, size, burst);
    nb = int'(len) + 1;
    r_q.delete(); mem_q.delete(); mem_cyc.delete();
    issued_tot = 0; accepted_tot = 0; max_out = 0; stab_err = 0;
    @(posedge pll_core_cpuclk); #1;
    biu_pad_araddr = a; biu_pad_arlen = len; biu_pad_arsize = size;
    biu_pad_arburst = burst; biu_pad_arid = id; biu_pad_arvalid = 1'b1;
    biu_pad_rready = pick_rready(mode, 0);
    waitc = 0;
    do begin @(negedge pll_core_cpuclk); waitc++; end
    while (!pad_biu_arready && waitc < 20);
    chk("ar_wait", pad_biu_arready, 1'b1);
    @(posedge pll_core_cpuclk); #1;
    biu_pad_arvalid = 1'b0;
    k = 1; waitc = 0;
    while (r_q.size() < nb && waitc < 64 * nb + 64) begin
      biu_pad_rready = pick_rready(mode, k);
      k++;
      @(posedge pll_core_cpuclk); #1;
      waitc++;
    end
    chk("beat_count", r_q.size(), nb);
    chk("arready_after", pad_biu_arready, 1'b1);
    biu_pad_rready = 1'b0;
    if (exp_err) begin
      chk("err_no_mem", mem_q.size(), 0);
    end else begin
      chk("mem_count", mem_q.size(), nb);
      for (int i = 0; i < nb && i < mem_q.size(); i++) begin
        wa = exp_a[i][19:4];
        chk("mem_addr", mem_q[i], wa);
      end
    end
    for (int i = 0; i < r_q.size() && i < nb; i++) begin
      wa = exp_a[i][19:4];
      chk("rdata", r_q[i].data, exp_err ? 128'd0 : word_of(wa));
      chk("rresp", r_q[i].resp, exp_err ? 2'b10 : 2'b00);
      chk("rlast", r_q[i].last, i == nb - 1);
      chk("rid", r_q[i].id, id);
    end
    chk("outstanding_le2", max_out <= 2, 1'b1);
    chk("stall_stable", stab_err, 0);
    if (mode == 0 && !exp_err && r_q.size() == nb && mem_cyc.size() == nb) begin
      chk("r_back_to_back", r_q[nb-1].cyc - r_q[0].cyc, nb - 1);
      chk("mem_back_to_back", mem_cyc[nb-1] - mem_cyc[0], nb - 1);
      chk("first_latency", r_q[0].cyc - mem_cyc[0], 1);
    end
  endtask

  initial begin
    logic [1:0]  b;
    logic [2:0]  s;
    logic [7:0]  l;
    logic [39:0] a;
    int          waitc;

    // Reset values, held across a clock edge
    #2;
    chk("rst_arready", pad_biu_arready, 1'b0);
    chk("rst_rvalid", pad_biu_rvalid, 1'b0);
    chk("rst_rlast", pad_biu_rlast, 1'b0);
    chk("rst_rid", pad_biu_rid, 8'h00);
    chk("rst_rresp", pad_biu_rresp, 2'b00);
    chk("rst_rdata", pad_biu_rdata, 128'd0);
    chk("rst_mem_cen", mem_cen, 1'b1);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    @(posedge pll_core_cpuclk); #1;
    chk("rst_arready_held", pad_biu_arready, 1'b0);
    pad_cpu_rst = 1'b0;
    @(negedge pll_core_cpuclk);
    chk("arready_before_edge", pad_biu_arready, 1'b0);
    @(posedge pll_core_cpuclk); #1;
    chk("arready_first_edge", pad_biu_arready, 1'b1);

    // Single-beat cycle-exact latency
    biu_pad_araddr = 40'h40; biu_pad_arlen = 8'd0; biu_pad_arsize = 3'd4;
    biu_pad_arburst = 2'b01; biu_pad_arid = 8'h5A; biu_pad_arvalid = 1'b1;
    biu_pad_rready = 1'b1;
    @(negedge pll_core_cpuclk);
    chk("sb_arready", pad_biu_arready, 1'b1);
    @(posedge pll_core_cpuclk); #1;
    biu_pad_arvalid = 1'b0;
    @(negedge pll_core_cpuclk);
    chk("sb_mem_cen", mem_cen, 1'b0);
    chk("sb_mem_addr", mem_addr, 16'h0004);
    chk("sb_rvalid_early", pad_biu_rvalid, 1'b0);
    chk("sb_arready_busy", pad_biu_arready, 1'b0);
    @(negedge pll_core_cpuclk);
    chk("sb_rvalid", pad_biu_rvalid, 1'b1);
    chk("sb_rlast", pad_biu_rlast, 1'b1);
    chk("sb_rresp", pad_biu_rresp, 2'b00);
    chk("sb_rid", pad_biu_rid, 8'h5A);
    chk("sb_rdata", pad_biu_rdata, word_of(16'h0004));
    @(negedge pll_core_cpuclk);
    chk("sb_arready_ret", pad_biu_arready, 1'b1);
    chk("sb_rvalid_done", pad_biu_rvalid, 1'b0);
    biu_pad_rready = 1'b0;

    // Directed bursts
    do_burst(40'h100, 8'd3, 3'd4, 2'b01, 8'h11, 0);
    do_burst(40'h130, 8'd3, 3'd4, 2'b10, 8'h22, 0);
    do_burst(40'h104, 8'd3, 3'd2, 2'b01, 8'h33, 0);
    do_burst(40'h250, 8'd4, 3'd4, 2'b00, 8'h44, 0);
    do_burst(40'h800, 8'd7, 3'd4, 2'b01, 8'h55, 1);
    do_burst(40'hFFFF0, 8'd2, 3'd4, 2'b01, 8'h56, 0);
    do_burst(40'h100000, 8'd1, 3'd4, 2'b01, 8'h66, 0);
    do_burst(40'h100, 8'd1, 3'd4, 2'b11, 8'h67, 0);
    do_burst(40'h100, 8'd1, 3'd5, 2'b01, 8'h68, 0);
    do_burst(40'h100, 8'd2, 3'd4, 2'b10, 8'h69, 1);

    // Reset during beat 2 of an 8-beat burst
    r_q.delete();
    @(posedge pll_core_cpuclk); #1;
    biu_pad_araddr = 40'h2000; biu_pad_arlen = 8'd7; biu_pad_arsize = 3'd4;
    biu_pad_arburst = 2'b01; biu_pad_arid = 8'h77; biu_pad_arvalid = 1'b1;
    biu_pad_rready = 1'b1;
    @(posedge pll_core_cpuclk); #1;
    biu_pad_arvalid = 1'b0;
    waitc = 0;
    while (r_q.size() < 2 && waitc < 50) begin
      @(posedge pll_core_cpuclk); #1;
      waitc++;
    end
    chk("mid_two_beats", r_q.size(), 2);
    chk("mid_rvalid_live", pad_biu_rvalid, 1'b1);
    pad_cpu_rst = 1'b1;
    #1;
    chk("mid_rst_rvalid", pad_biu_rvalid, 1'b0);
    chk("mid_rst_mem_cen", mem_cen, 1'b1);
    chk("mid_rst_arready", pad_biu_arready, 1'b0);
    chk("mid_rst_rlast", pad_biu_rlast, 1'b0);
    biu_pad_rready = 1'b0;
    @(posedge pll_core_cpuclk); #1;
    pad_cpu_rst = 1'b0;
    @(posedge pll_core_cpuclk); #1;
    chk("post_rst_arready", pad_biu_arready, 1'b1);
    do_burst(40'h3450, 8'd0, 3'd4, 2'b01, 8'h78, 0);

    // Random bursts
    for (int t = 0; t < 40; t++) begin
      b = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) b = 2'b11;
      s = 3'($urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) s = 3'd5;
      l = 8'($urandom_range(0, 15));
      if (b == 2'b10 && $urandom_range(0, 7) != 0) l = 8'((2 << $urandom_range(0, 3)) - 1);
      a = {20'h0, 20'($urandom)};
      if ($urandom_range(0, 9) == 0) a[20 + $urandom_range(0, 19)] = 1'b1;
      do_burst(a, l, s, b, 8'($urandom), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
